// File: rtl/uart_imem_loader.sv
// UART boot loader: receives a framed program image and writes it word by word into imem,
// keeping the core in reset while a load is in flight.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int ADDR_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic [ADDR_WIDTH-1:0] imem_write_address,
    output logic [31:0]           imem_write_data,
    output logic                  imem_write_enable,
    output logic                  core_hold,
    output logic                  load_done,
    output logic                  load_error
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]      DEPTH    = 17'(1 << ADDR_WIDTH);
    localparam logic [7:0]       SYNC     = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR} loadState_t;

    rxState_t             rxState, rxNext;
    loadState_t           state, stateNext;
    logic                 rxMeta, rxSync, rxPrev;
    logic [CNT_W-1:0]     clkCnt;
    logic [2:0]           bitIdx;
    logic [7:0]           shiftReg;
    logic [7:0]           rxByte;
    logic                 byteValid, framingErr;
    logic [7:0]           lenLo;
    logic [15:0]          lenValue;
    logic [ADDR_WIDTH-1:0] wordIdx, lastIdx;
    logic [1:0]           lane;
    logic [7:0]           checksum;
    logic [23:0]          wordBuf;
    logic [TMO_W-1:0]     timeoutCnt;
    logic                 timeoutHit, inFrame;

    assign rxByte     = shiftReg;
    assign lenValue   = {rxByte, lenLo};
    assign timeoutHit = (timeoutCnt == TMO_LAST);
    assign inFrame    = state inside {LEN_LO, LEN_HI, DATA, CHK};
    assign core_hold  = inFrame || (state == ERROR);

    always_ff @(posedge clock) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= uart_rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    // Start is armed only by a falling edge, so a line stuck low after a bad stop bit is not re-read.
    always_comb begin
        rxNext = rxState;
        case (rxState)
            RX_IDLE:  if (rxPrev && !rxSync) rxNext = RX_START;
            RX_START: if (clkCnt == HALF_BIT) rxNext = rxSync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (clkCnt == FULL_BIT && bitIdx == 3'd7) rxNext = RX_STOP;
            RX_STOP:  if (clkCnt == FULL_BIT) rxNext = RX_IDLE;
            default:  rxNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rxState    <= RX_IDLE;
            clkCnt     <= '0;
            bitIdx     <= '0;
            shiftReg   <= '0;
            byteValid  <= 1'b0;
            framingErr <= 1'b0;
        end else begin
            rxState    <= rxNext;
            byteValid  <= 1'b0;
            framingErr <= 1'b0;
            if (rxState == RX_IDLE || rxNext != rxState || clkCnt == FULL_BIT)
                clkCnt <= '0;
            else
                clkCnt <= clkCnt + CNT_W'(1);
            if (rxState == RX_START)
                bitIdx <= '0;
            if (rxState == RX_DATA && clkCnt == FULL_BIT) begin
                shiftReg <= {rxSync, shiftReg[7:1]};
                bitIdx   <= bitIdx + 3'd1;
            end
            if (rxState == RX_STOP && clkCnt == FULL_BIT) begin
                byteValid  <= rxSync;
                framingErr <= !rxSync;
            end
        end
    end

    // A received byte always takes priority over a timeout that fires in the same cycle.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:        if (byteValid && rxByte == SYNC) stateNext = LEN_LO;
            LEN_LO:      if (byteValid) stateNext = LEN_HI;
            LEN_HI:      if (byteValid)
                             stateNext = (lenValue == 16'd0 || {1'b0, lenValue} > DEPTH) ? ERROR : DATA;
            DATA:        if (byteValid && lane == 2'd3 && wordIdx == lastIdx) stateNext = CHK;
            CHK:         if (byteValid) stateNext = (rxByte == checksum) ? DONE : ERROR;
            DONE, ERROR: if (byteValid && rxByte == SYNC) stateNext = LEN_LO;
            default:     stateNext = IDLE;
        endcase
        if (inFrame && !byteValid && (framingErr || timeoutHit))
            stateNext = ERROR;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            lenLo              <= '0;
            lastIdx            <= '0;
            wordIdx            <= '0;
            lane               <= '0;
            checksum           <= '0;
            wordBuf            <= '0;
            timeoutCnt         <= '0;
            imem_write_address <= '0;
            imem_write_data    <= '0;
            imem_write_enable  <= 1'b0;
            load_done          <= 1'b0;
            load_error         <= 1'b0;
        end else begin
            state             <= stateNext;
            imem_write_enable <= 1'b0;
            if (!inFrame || byteValid)
                timeoutCnt <= '0;
            else if (!timeoutHit)
                timeoutCnt <= timeoutCnt + TMO_W'(1);
            if (byteValid) begin
                case (state)
                    LEN_LO: lenLo <= rxByte;
                    LEN_HI: begin
                        wordIdx  <= '0;
                        lane     <= '0;
                        checksum <= '0;
                        lastIdx  <= ADDR_WIDTH'(lenValue - 16'd1);
                    end
                    DATA: begin
                        checksum <= checksum ^ rxByte;
                        lane     <= lane + 2'd1;
                        case (lane)
                            2'd0:    wordBuf[7:0]   <= rxByte;
                            2'd1:    wordBuf[15:8]  <= rxByte;
                            2'd2:    wordBuf[23:16] <= rxByte;
                            default: begin
                                imem_write_enable  <= 1'b1;
                                imem_write_address <= wordIdx;
                                imem_write_data    <= {rxByte, wordBuf};
                                wordIdx            <= wordIdx + ADDR_WIDTH'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            if (stateNext == LEN_LO && state != LEN_LO) begin
                load_done  <= 1'b0;
                load_error <= 1'b0;
            end
            if (stateNext == DONE && state != DONE)
                load_done <= 1'b1;
            if (stateNext == ERROR && state != ERROR)
                load_error <= 1'b1;
        end
    end
endmodule
